// File: rtl/rv32im_branch_unit.sv
// Execute-stage branch/jump resolver: captures control alongside the ALU, resolves
// one cycle later from the ALU's registered flags, and drives redirect, flush and link.
module rv32im_branch_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  input  logic            data_ready_i,
  input  logic            is_branch_i,
  input  logic            is_jal_i,
  input  logic            is_jalr_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic            equal_i,
  input  logic            less_i,
  input  logic            less_signed_i,
  input  logic [XLEN-1:0] alu_result_i,
  output logic            jump_o,
  output logic [XLEN-1:0] jump_target_o,
  output logic [XLEN-1:0] link_o,
  output logic            trap_o,
  output logic            flush_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  localparam logic [3:0] LP_FLUSH = 4'(FLUSH_CYCLES);

  state_t          r_state;
  state_t          w_state_next;
  logic [3:0]      r_cnt;

  logic            r_is_branch;
  logic            r_is_jal;
  logic            r_is_jalr;
  logic [2:0]      r_funct3;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_imm;

  logic            r_jump;
  logic            r_trap;
  logic [XLEN-1:0] r_target;
  logic [XLEN-1:0] r_link;

  logic            w_new_jump;
  logic            w_is_jump;
  logic            w_cond;
  logic            w_taken;
  logic            w_can_accept;
  logic            w_capture;
  logic [XLEN-1:0] w_target;

  assign w_new_jump = is_branch_i | is_jal_i | is_jalr_i;
  assign w_is_jump  = r_is_jal | r_is_jalr;

  always_comb begin
    w_cond = 1'b0;
    case (r_funct3)
      3'b000:  w_cond = equal_i;
      3'b001:  w_cond = !equal_i;
      3'b100:  w_cond = less_signed_i;
      3'b101:  w_cond = !less_signed_i;
      3'b110:  w_cond = less_i;
      3'b111:  w_cond = !less_i;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_taken = (r_state == S_RESOLVE) && (w_is_jump || (r_is_branch && w_cond));

  // JALR takes the ALU sum with bit 0 forced low; branches and JAL wrap freely.
  assign w_target = r_is_jalr ? (alu_result_i & ~XLEN'(1)) : (r_pc + r_imm);

  // A taken resolution squashes anything arriving in the same cycle.
  assign w_can_accept = (r_state == S_IDLE) || ((r_state == S_RESOLVE) && !w_taken);
  assign w_capture    = data_ready_i && w_can_accept && w_new_jump;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_capture) w_state_next = S_RESOLVE;
      end
      S_RESOLVE: begin
        if (w_taken)        w_state_next = S_FLUSH;
        else if (w_capture) w_state_next = S_RESOLVE;
        else                w_state_next = S_IDLE;
      end
      S_FLUSH: begin
        if (r_cnt <= 4'd1) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    flush_o = (r_state == S_FLUSH);
    busy_o  = (r_state != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_cnt <= 4'd0;
    end else if (w_taken) begin
      r_cnt <= LP_FLUSH;
    end else if ((r_state == S_FLUSH) && (r_cnt != 4'd0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_is_branch <= 1'b0;
      r_is_jal    <= 1'b0;
      r_is_jalr   <= 1'b0;
      r_funct3    <= 3'd0;
      r_pc        <= '0;
      r_imm       <= '0;
    end else if (w_capture) begin
      r_is_branch <= is_branch_i;
      r_is_jal    <= is_jal_i;
      r_is_jalr   <= is_jalr_i;
      r_funct3    <= funct3_i;
      r_pc        <= pc_i;
      r_imm       <= imm_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      r_jump   <= 1'b0;
      r_trap   <= 1'b0;
      r_target <= '0;
      r_link   <= '0;
    end else begin
      r_jump <= 1'b0;
      r_trap <= 1'b0;
      if (w_taken) begin
        // A misaligned target still loads the target and flushes, but traps instead.
        r_jump   <= !w_target[1];
        r_trap   <= w_target[1];
        r_target <= w_target;
        if (w_is_jump) r_link <= r_pc + XLEN'(4);
      end
    end
  end

  assign jump_o        = r_jump;
  assign trap_o        = r_trap;
  assign jump_target_o = r_target;
  assign link_o        = r_link;

  a_pulse_exclusive : assert property (@(posedge clk_i) disable iff (!reset_ni) !(jump_o && trap_o));

endmodule
